// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl
//   Controller for a direct-mapped, write-back, write-allocate cache.
//   It sits between a CPU request port and a 128-bit memory port. It owns the
//   tag array (valid/dirty/tag) and the data array, and it sequences hit,
//   write-back and refill. It also keeps saturating hit and miss counters.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   cpu_req_*         CPU request: byte address, write data, rw (1=write), valid.
//                     The CPU holds the request until cpu_res_ready.
//   cpu_res_data      read data; holds its last value between pulses
//   cpu_res_ready     one-cycle completion pulse
//   mem_req_*         memory request: line-aligned address, write-back line,
//                     rw (1=write-back), valid. Valid is held until mem_data_ready.
//   mem_data_data     refill line
//   mem_data_ready    one-cycle memory response pulse
//   hit_cnt/miss_cnt  saturating counts of first-compare hits and misses
module dm_cache_ctrl #(
  parameter int TAGMSB      = 31,
  parameter int TAGLSB      = 12,
  parameter int CACHE_INDEX = 128,
  parameter int INDEX_BIT   = 7,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cpu_req_addr,
  input  logic [31:0]      cpu_req_data,
  input  logic             cpu_req_rw,
  input  logic             cpu_req_valid,
  output logic [31:0]      cpu_res_data,
  output logic             cpu_res_ready,
  output logic [31:0]      mem_req_addr,
  output logic [127:0]     mem_req_data,
  output logic             mem_req_rw,
  output logic             mem_req_valid,
  input  logic [127:0]     mem_data_data,
  input  logic             mem_data_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = TAGMSB - TAGLSB + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  // ALLOCATE runs in phases. ISSUE raises the refill read that follows a
  // write-back. WAIT waits for the memory response. FILL writes the captured
  // line into the arrays. Because of FILL, the CPU sees ready three cycles
  // after mem_data_ready.
  typedef enum logic [1:0] {
    AL_ISSUE = 2'd0,
    AL_WAIT  = 2'd1,
    AL_FILL  = 2'd2
  } alloc_t;

  state_t state, state_nxt;
  alloc_t alloc_ph, alloc_nxt;

  logic [31:0]            req_addr;
  logic [31:0]            req_data;
  logic                   req_rw;
  logic                   first_cmp;
  logic [CACHE_INDEX-1:0] valid_bits;
  logic [CACHE_INDEX-1:0] dirty_bits;
  logic [TAG_W-1:0]       tag_mem  [CACHE_INDEX];
  logic [127:0]           data_mem [CACHE_INDEX];
  logic [127:0]           refill_line;

  logic [INDEX_BIT-1:0]   idx;
  logic [TAG_W-1:0]       req_tag;
  logic [1:0]             word_sel;
  logic [127:0]           cur_line;
  logic [TAG_W-1:0]       cur_tag;
  logic                   hit;
  logic                   victim_dirty;
  logic                   take_req;
  logic                   unused_addr_bits;

  function automatic logic [31:0] get_word(input logic [127:0] line, input logic [1:0] sel);
    return line[{sel, 5'b0} +: 32];
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] line, input logic [1:0] sel,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = line;
    r[{sel, 5'b0} +: 32] = w;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign idx          = req_addr[INDEX_BIT+3:4];
  assign req_tag      = req_addr[TAGMSB:TAGLSB];
  assign word_sel     = req_addr[3:2];
  assign cur_line     = data_mem[idx];
  assign cur_tag      = tag_mem[idx];
  assign hit          = valid_bits[idx] && (cur_tag == req_tag);
  assign victim_dirty = valid_bits[idx] && dirty_bits[idx];
  // While ready is high, the CPU may still show the old request. Do not take it again.
  assign take_req     = cpu_req_valid && !cpu_res_ready;
  // Address bit 11 sits between the tag and the index and is not stored.
  assign unused_addr_bits = ^{req_addr[TAGLSB-1], req_addr[1:0]};

  always_comb begin
    state_nxt = state;
    alloc_nxt = alloc_ph;
    case (state)
      IDLE: begin
        if (take_req) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          state_nxt = IDLE;
        end else if (victim_dirty) begin
          state_nxt = WRITE_BACK;
        end else begin
          state_nxt = ALLOCATE;
          alloc_nxt = AL_WAIT;
        end
      end
      WRITE_BACK: begin
        if (mem_data_ready) begin
          state_nxt = ALLOCATE;
          alloc_nxt = AL_ISSUE;
        end
      end
      ALLOCATE: begin
        case (alloc_ph)
          AL_ISSUE: alloc_nxt = AL_WAIT;
          AL_WAIT:  if (mem_data_ready) alloc_nxt = AL_FILL;
          AL_FILL: begin
            state_nxt = COMPARE;
            alloc_nxt = AL_WAIT;
          end
          default:  alloc_nxt = AL_WAIT;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      alloc_ph      <= AL_WAIT;
      first_cmp     <= 1'b0;
      valid_bits    <= '0;
      dirty_bits    <= '0;
      cpu_res_data  <= '0;
      cpu_res_ready <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_rw    <= 1'b0;
      mem_req_valid <= 1'b0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      alloc_ph      <= alloc_nxt;
      cpu_res_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (take_req) first_cmp <= 1'b1;
        end
        COMPARE: begin
          // The guaranteed hit after a refill is not counted.
          first_cmp <= 1'b0;
          if (first_cmp) begin
            if (hit) hit_cnt  <= sat_inc(hit_cnt);
            else     miss_cnt <= sat_inc(miss_cnt);
          end
          if (hit) begin
            cpu_res_ready <= 1'b1;
            if (req_rw) dirty_bits[idx] <= 1'b1;
            else        cpu_res_data    <= get_word(cur_line, word_sel);
          end else begin
            mem_req_valid <= 1'b1;
            if (victim_dirty) begin
              mem_req_rw   <= 1'b1;
              mem_req_addr <= {cur_tag, 1'b0, idx, 4'h0};
              mem_req_data <= cur_line;
            end else begin
              mem_req_rw   <= 1'b0;
              mem_req_addr <= {req_tag, 1'b0, idx, 4'h0};
            end
          end
        end
        WRITE_BACK: begin
          if (mem_data_ready) mem_req_valid <= 1'b0;
        end
        ALLOCATE: begin
          case (alloc_ph)
            AL_ISSUE: begin
              mem_req_valid <= 1'b1;
              mem_req_rw    <= 1'b0;
              mem_req_addr  <= {req_tag, 1'b0, idx, 4'h0};
            end
            AL_WAIT: begin
              if (mem_data_ready) mem_req_valid <= 1'b0;
            end
            AL_FILL: begin
              valid_bits[idx] <= 1'b1;
              dirty_bits[idx] <= 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Request latch and arrays. These registers have no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && take_req) begin
      req_addr <= cpu_req_addr;
      req_data <= cpu_req_data;
      req_rw   <= cpu_req_rw;
    end
    if (state == COMPARE && hit && req_rw)
      data_mem[idx] <= put_word(cur_line, word_sel, req_data);
    if (state == ALLOCATE && alloc_ph == AL_WAIT && mem_data_ready)
      refill_line <= mem_data_data;
    if (state == ALLOCATE && alloc_ph == AL_FILL) begin
      data_mem[idx] <= refill_line;
      tag_mem[idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl
//   Directed bench for dm_cache_ctrl. A transaction-level cache and memory
//   model predicts the responses. A second instance with 2-bit counters
//   exercises counter saturation.
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cpu_req_addr, cpu_req_data;
  logic         cpu_req_rw, cpu_req_valid;
  logic [31:0]  cpu_res_data;
  logic         cpu_res_ready;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_rw, mem_req_valid;
  logic [127:0] mem_data_data;
  logic         mem_data_ready;
  logic [31:0]  hit_cnt, miss_cnt;

  logic [31:0]  s_res_data;
  logic         s_res_ready;
  logic [31:0]  s_mem_addr;
  logic [127:0] s_mem_data;
  logic         s_mem_rw, s_mem_valid;
  logic [1:0]   s_hit, s_miss;

  always #5 clk = ~clk;

  dm_cache_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_rw(cpu_req_rw), .cpu_req_valid(cpu_req_valid),
    .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_rw(mem_req_rw), .mem_req_valid(mem_req_valid),
    .mem_data_data(mem_data_data), .mem_data_ready(mem_data_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  dm_cache_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_rw(cpu_req_rw), .cpu_req_valid(cpu_req_valid),
    .cpu_res_data(s_res_data), .cpu_res_ready(s_res_ready),
    .mem_req_addr(s_mem_addr), .mem_req_data(s_mem_data),
    .mem_req_rw(s_mem_rw), .mem_req_valid(s_mem_valid),
    .mem_data_data(mem_data_data), .mem_data_ready(mem_data_ready),
    .hit_cnt(s_hit), .miss_cnt(s_miss)
  );

  // Model state
  logic         m_valid [128];
  logic         m_dirty [128];
  logic [19:0]  m_tag   [128];
  logic [127:0] m_line  [128];
  logic [127:0] backing [logic [31:0]];
  logic [31:0]  n_hit, n_miss;

  // Expectations for the compare process
  logic         exp_mem_active = 1'b0;
  logic [31:0]  exp_mem_addr = '0;
  logic         exp_mem_rw = 1'b0;
  logic [127:0] exp_mem_data = '0;
  logic         exp_rd_chk = 1'b0;
  logic [31:0]  exp_rd = '0;
  logic [31:0]  hold_data = '0;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return {a ^ 32'hA5A5_0003, a + 32'd2, a + 32'd1, a};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_line[i]  = '0;
    end
    n_hit = '0;
    n_miss = '0;
    hold_data = '0;
    exp_mem_active = 1'b0;
    exp_rd_chk = 1'b0;
  endtask

  // Compare process: runs 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (!exp_mem_active) begin
        chk("mem_req_valid_unexpected", mem_req_valid, 1'b0);
      end else if (mem_req_valid) begin
        chk("mem_req_addr", mem_req_addr, exp_mem_addr);
        chk("mem_req_rw", mem_req_rw, exp_mem_rw);
        if (exp_mem_rw) chk("mem_req_data", mem_req_data, exp_mem_data);
      end
      if (cpu_res_ready) begin
        if (exp_rd_chk) hold_data = exp_rd;
        chk("hit_cnt", hit_cnt, n_hit);
        chk("miss_cnt", miss_cnt, n_miss);
        chk("sat_hit_cnt", s_hit, (n_hit > 32'd3) ? 2'd3 : n_hit[1:0]);
        chk("sat_miss_cnt", s_miss, (n_miss > 32'd3) ? 2'd3 : n_miss[1:0]);
      end
      chk("cpu_res_data", cpu_res_data, hold_data);
    end
  end

  task automatic wait_mem(input string name);
    int n;
    n = 0;
    while (!mem_req_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, mem_req_valid, 1'b1);
  endtask

  task automatic pulse_mem(input logic [127:0] d);
    @(negedge clk);
    @(negedge clk);
    mem_data_data  = d;
    mem_data_ready = 1'b1;
    @(negedge clk);
    mem_data_ready = 1'b0;
    mem_data_data  = '0;
    chk("mem_req_valid_drop", mem_req_valid, 1'b0);
  endtask

  task automatic do_req(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic wb_seen,
                        output logic [31:0] wb_addr, output logic [127:0] wb_data,
                        output logic [31:0] rf_addr);
    logic [6:0]   idx;
    logic [19:0]  tag;
    logic [1:0]   w;
    logic         hit, need_wb;
    logic [31:0]  vaddr, laddr;
    logic [127:0] vline, fill;
    int           lat;
    assert (addr[11] == 1'b0) else $error("address bit 11 set: %0h", addr);
    idx = addr[10:4];
    tag = addr[31:12];
    w   = addr[3:2];
    wb_seen = 1'b0; wb_addr = '0; wb_data = '0; rf_addr = '0; rdata = '0;
    laddr = {tag, 1'b0, idx, 4'h0};
    hit = m_valid[idx] && (m_tag[idx] == tag);
    need_wb = !hit && m_valid[idx] && m_dirty[idx];
    vaddr = {m_tag[idx], 1'b0, idx, 4'h0};
    vline = m_line[idx];
    if (hit) n_hit = sat32(n_hit);
    else     n_miss = sat32(n_miss);
    if (need_wb) backing[vaddr] = vline;
    fill = mem_line(laddr);
    if (!hit) begin
      m_line[idx]  = fill;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    if (rw) begin
      m_line[idx][{w, 5'b0} +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end

    @(negedge clk);
    exp_rd = m_line[idx][{w, 5'b0} +: 32];
    exp_rd_chk = !rw;
    exp_mem_active = !hit;
    exp_mem_rw   = need_wb;
    exp_mem_addr = need_wb ? vaddr : laddr;
    exp_mem_data = vline;
    cpu_req_addr = addr; cpu_req_data = wdata; cpu_req_rw = rw; cpu_req_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    if (!hit) begin
      if (need_wb) begin
        wait_mem("wb_req_timeout");
        wb_seen = mem_req_valid && mem_req_rw;
        wb_addr = mem_req_addr;
        wb_data = mem_req_data;
        pulse_mem('0);
        exp_mem_rw   = 1'b0;
        exp_mem_addr = laddr;
      end
      wait_mem("refill_req_timeout");
      rf_addr = mem_req_addr;
      pulse_mem(fill);
      exp_mem_active = 1'b0;
      lat = 1;
    end
    while (!cpu_res_ready && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("ready_latency", lat, hit ? 2 : 3);
    rdata = cpu_res_data;
    cpu_req_valid = 1'b0;
  endtask

  logic [31:0]  rd, wa, ra;
  logic         wbs;
  logic [127:0] wd;

  initial begin
    rst_n = 1'b1;
    cpu_req_addr = '0; cpu_req_data = '0; cpu_req_rw = 1'b0; cpu_req_valid = 1'b0;
    mem_data_data = '0; mem_data_ready = 1'b0;
    model_reset();
    backing[32'h0000_0040] = {32'd4, 32'd3, 32'd2, 32'd1};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_res_ready", cpu_res_ready, 1'b0);
    chk("rst_cpu_res_data", cpu_res_data, 32'd0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    rst_n = 1'b1;

    // 1: cold read miss
    do_req(32'h0000_0040, 1'b0, 32'd0, rd, wbs, wa, wd, ra);
    chk("t1_data", rd, 32'd1);
    chk("t1_refill_addr", ra, 32'h0000_0040);
    chk("t1_no_wb", wbs, 1'b0);
    chk("t1_miss_cnt", miss_cnt, 32'd1);
    // 2: read hit
    do_req(32'h0000_004C, 1'b0, 32'd0, rd, wbs, wa, wd, ra);
    chk("t2_data", rd, 32'd4);
    chk("t2_hit_cnt", hit_cnt, 32'd1);
    // 3: write hit, then read back
    do_req(32'h0000_0044, 1'b1, 32'hDEAD_BEEF, rd, wbs, wa, wd, ra);
    do_req(32'h0000_0044, 1'b0, 32'd0, rd, wbs, wa, wd, ra);
    chk("t3_data", rd, 32'hDEAD_BEEF);
    // 4: conflict miss on dirty line
    do_req(32'h0000_1040, 1'b0, 32'd0, rd, wbs, wa, wd, ra);
    chk("t4_wb_seen", wbs, 1'b1);
    chk("t4_wb_addr", wa, 32'h0000_0040);
    chk("t4_wb_data", wd, {32'd4, 32'd3, 32'hDEAD_BEEF, 32'd1});
    chk("t4_refill_addr", ra, 32'h0000_1040);
    chk("t4_data", rd, 32'h0000_1040);
    // 5: write miss to clean line, then hit and dirty eviction
    do_req(32'h2000_0080, 1'b1, 32'h1234_5678, rd, wbs, wa, wd, ra);
    chk("t5_no_wb", wbs, 1'b0);
    chk("t5_refill_addr", ra, 32'h2000_0080);
    do_req(32'h2000_0080, 1'b0, 32'd0, rd, wbs, wa, wd, ra);
    chk("t5_read_back", rd, 32'h1234_5678);
    do_req(32'h2000_1080, 1'b0, 32'd0, rd, wbs, wa, wd, ra);
    chk("t5_wb_addr", wa, 32'h2000_0080);
    chk("t5_wb_word0", wd[31:0], 32'h1234_5678);
    do_req(32'h2000_1084, 1'b0, 32'd0, rd, wbs, wa, wd, ra);
    chk("t5_hit_cnt", hit_cnt, 32'd5);
    chk("t5_sat_hit", s_hit, 2'd3);
    chk("t5_sat_miss", s_miss, 2'd3);

    // 6: reset while waiting in ALLOCATE
    @(negedge clk);
    exp_mem_active = 1'b1; exp_mem_rw = 1'b0; exp_mem_addr = 32'h0000_0300; exp_rd_chk = 1'b0;
    cpu_req_addr = 32'h0000_0300; cpu_req_rw = 1'b0; cpu_req_valid = 1'b1;
    @(posedge clk);
    wait_mem("t6_req_timeout");
    rst_n = 1'b0;
    cpu_req_valid = 1'b0;
    model_reset();
    #1;
    chk("t6_mem_req_valid", mem_req_valid, 1'b0);
    chk("t6_hit_cnt", hit_cnt, 32'd0);
    chk("t6_miss_cnt", miss_cnt, 32'd0);
    chk("t6_cpu_res_data", cpu_res_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_data_data = {4{32'hBAD0_BAD0}};
    mem_data_ready = 1'b1;
    @(negedge clk);
    mem_data_ready = 1'b0;
    mem_data_data = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_late_ready_valid", mem_req_valid, 1'b0);
      chk("t6_late_ready_res", cpu_res_ready, 1'b0);
    end
    do_req(32'h0000_0044, 1'b0, 32'd0, rd, wbs, wa, wd, ra);
    chk("t6_refill_addr", ra, 32'h0000_0040);
    chk("t6_data", rd, 32'hDEAD_BEEF);
    chk("t6_miss_cnt", miss_cnt, 32'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
